// File: rtl/axi_master_arbiter_pkg.sv
// rtl/axi_master_arbiter_pkg.sv - shared state encoding and AXI constants for the master arbiter
package axi_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_IFU = 2'd1,
    ST_RD_LSU = 2'd2,
    ST_WR_LSU = 2'd3
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  // Bit positions in the two-way request/grant vectors
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

endpackage

// File: rtl/axi_master_arbiter_rr_arb2.sv
// rtl/axi_master_arbiter_rr_arb2.sv - two-way IFU/LSU request to one-hot grant with fairness memory
module rr_arb2
  import axi_master_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 0: IFU was granted last (reset value, so the LSU takes the first tie)
  logic last_lsu;

  always_comb begin
    grant = 2'b00;
    if (req[GNT_LSU] && req[GNT_IFU]) begin
      if ((PRIO_MODE == 1) || !last_lsu) grant[GNT_LSU] = 1'b1;
      else                               grant[GNT_IFU] = 1'b1;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_lsu <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      last_lsu <= grant[GNT_LSU];
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// rtl/axi_master_arbiter.sv - shares one AXI4 master port between IFU reads and LSU reads/writes
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [ID_W-1:0]   ifu_arid,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic [ID_W-1:0]   ifu_rid,
  input  logic              ifu_rready,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [ID_W-1:0]   lsu_arid,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic [ID_W-1:0]   lsu_rid,
  input  logic              lsu_rready,
  input  logic              lsu_awvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic [ID_W-1:0]   lsu_awid,
  input  logic [7:0]        lsu_awlen,
  input  logic [2:0]        lsu_awsize,
  input  logic [1:0]        lsu_awburst,
  output logic              lsu_awready,
  input  logic              lsu_wvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic              lsu_wlast,
  output logic              lsu_wready,
  output logic              lsu_bvalid,
  output logic [1:0]        lsu_bresp,
  output logic [ID_W-1:0]   lsu_bid,
  input  logic              lsu_bready,
  output logic              out_arvalid,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [ID_W-1:0]   out_arid,
  output logic [7:0]        out_arlen,
  output logic [2:0]        out_arsize,
  output logic [1:0]        out_arburst,
  input  logic              out_arready,
  input  logic              out_rvalid,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,
  input  logic [ID_W-1:0]   out_rid,
  output logic              out_rready,
  output logic              out_awvalid,
  output logic [ADDR_W-1:0] out_awaddr,
  output logic [ID_W-1:0]   out_awid,
  output logic [7:0]        out_awlen,
  output logic [2:0]        out_awsize,
  output logic [1:0]        out_awburst,
  input  logic              out_awready,
  output logic              out_wvalid,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic              out_wlast,
  input  logic              out_wready,
  input  logic              out_bvalid,
  input  logic [1:0]        out_bresp,
  input  logic [ID_W-1:0]   out_bid,
  output logic              out_bready
);

  arb_state_e state_q, state_d;
  logic [1:0] req, grant;

  assign req[GNT_IFU] = ifu_arvalid;
  assign req[GNT_LSU] = lsu_arvalid | lsu_awvalid;

  rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .update (state_q == ST_IDLE),
    .grant  (grant)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The grant is held until the final response beat so responses route back unambiguously
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant[GNT_LSU])      state_d = lsu_awvalid ? ST_WR_LSU : ST_RD_LSU;
        else if (grant[GNT_IFU]) state_d = ST_RD_IFU;
      end
      ST_RD_IFU, ST_RD_LSU: if (out_rvalid && out_rready && out_rlast) state_d = ST_IDLE;
      ST_WR_LSU:            if (out_bvalid && out_bready) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Unselected channels are forced to zero so no master ever sees another's payload
  always_comb begin
    out_arvalid = 1'b0; out_araddr = '0; out_arid = '0;
    out_arlen   = '0;   out_arsize = '0; out_arburst = '0;
    out_rready  = 1'b0;
    out_awvalid = 1'b0; out_awaddr = '0; out_awid = '0;
    out_awlen   = '0;   out_awsize = '0; out_awburst = '0;
    out_wvalid  = 1'b0; out_wdata  = '0; out_wstrb = '0; out_wlast = 1'b0;
    out_bready  = 1'b0;
    ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0;
    ifu_rresp   = '0;   ifu_rlast  = 1'b0; ifu_rid   = '0;
    lsu_arready = 1'b0; lsu_rvalid = 1'b0; lsu_rdata = '0;
    lsu_rresp   = '0;   lsu_rlast  = 1'b0; lsu_rid   = '0;
    lsu_awready = 1'b0; lsu_wready = 1'b0;
    lsu_bvalid  = 1'b0; lsu_bresp  = '0;   lsu_bid   = '0;
    case (state_q)
      ST_RD_IFU: begin
        out_arvalid = ifu_arvalid; out_araddr = ifu_araddr; out_arid    = ifu_arid;
        out_arlen   = ifu_arlen;   out_arsize = ifu_arsize; out_arburst = ifu_arburst;
        ifu_arready = out_arready; out_rready = ifu_rready;
        ifu_rvalid  = out_rvalid;  ifu_rdata  = out_rdata;  ifu_rresp   = out_rresp;
        ifu_rlast   = out_rlast;   ifu_rid    = out_rid;
      end
      ST_RD_LSU: begin
        out_arvalid = lsu_arvalid; out_araddr = lsu_araddr; out_arid    = lsu_arid;
        out_arlen   = lsu_arlen;   out_arsize = lsu_arsize; out_arburst = lsu_arburst;
        lsu_arready = out_arready; out_rready = lsu_rready;
        lsu_rvalid  = out_rvalid;  lsu_rdata  = out_rdata;  lsu_rresp   = out_rresp;
        lsu_rlast   = out_rlast;   lsu_rid    = out_rid;
      end
      ST_WR_LSU: begin
        out_awvalid = lsu_awvalid; out_awaddr = lsu_awaddr; out_awid    = lsu_awid;
        out_awlen   = lsu_awlen;   out_awsize = lsu_awsize; out_awburst = lsu_awburst;
        lsu_awready = out_awready;
        out_wvalid  = lsu_wvalid;  out_wdata  = lsu_wdata;  out_wstrb   = lsu_wstrb;
        out_wlast   = lsu_wlast;   lsu_wready = out_wready;
        lsu_bvalid  = out_bvalid;  lsu_bresp  = out_bresp;  lsu_bid     = out_bid;
        out_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb/tb_axi_master_arbiter.sv - scoreboard bench for axi_master_arbiter with a reactive slave
module tb_axi_master_arbiter;
  import axi_master_arbiter_pkg::*;

  localparam int B_DELAY = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic ifu_arvalid = 0; logic [31:0] ifu_araddr = 0; logic [3:0] ifu_arid = 0;
  logic [7:0] ifu_arlen = 0; logic [2:0] ifu_arsize = 0; logic [1:0] ifu_arburst = 0;
  logic ifu_arready, ifu_rvalid, ifu_rlast; logic [31:0] ifu_rdata; logic [1:0] ifu_rresp;
  logic [3:0] ifu_rid; logic ifu_rready = 1;
  logic lsu_arvalid = 0; logic [31:0] lsu_araddr = 0; logic [3:0] lsu_arid = 0;
  logic [7:0] lsu_arlen = 0; logic [2:0] lsu_arsize = 0; logic [1:0] lsu_arburst = 0;
  logic lsu_arready, lsu_rvalid, lsu_rlast; logic [31:0] lsu_rdata; logic [1:0] lsu_rresp;
  logic [3:0] lsu_rid; logic lsu_rready = 1;
  logic lsu_awvalid = 0; logic [31:0] lsu_awaddr = 0; logic [3:0] lsu_awid = 0;
  logic [7:0] lsu_awlen = 0; logic [2:0] lsu_awsize = 0; logic [1:0] lsu_awburst = 0;
  logic lsu_awready;
  logic lsu_wvalid = 0; logic [31:0] lsu_wdata = 0; logic [3:0] lsu_wstrb = 0; logic lsu_wlast = 0;
  logic lsu_wready, lsu_bvalid; logic [1:0] lsu_bresp; logic [3:0] lsu_bid; logic lsu_bready = 1;
  logic out_arvalid; logic [31:0] out_araddr; logic [3:0] out_arid; logic [7:0] out_arlen;
  logic [2:0] out_arsize; logic [1:0] out_arburst; logic out_arready = 1;
  logic out_rvalid = 0; logic [31:0] out_rdata = 0; logic [1:0] out_rresp = 0;
  logic out_rlast = 0; logic [3:0] out_rid = 0; logic out_rready;
  logic out_awvalid; logic [31:0] out_awaddr; logic [3:0] out_awid; logic [7:0] out_awlen;
  logic [2:0] out_awsize; logic [1:0] out_awburst; logic out_awready = 1;
  logic out_wvalid; logic [31:0] out_wdata; logic [3:0] out_wstrb; logic out_wlast;
  logic out_wready = 1; logic out_bvalid = 0; logic [1:0] out_bresp = 0; logic [3:0] out_bid = 0;
  logic out_bready;

  axi_master_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .PRIO_MODE(0)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
    .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
    .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid), .lsu_bready(lsu_bready),
    .out_arvalid(out_arvalid), .out_araddr(out_araddr), .out_arid(out_arid),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_arready(out_arready), .out_rvalid(out_rvalid), .out_rdata(out_rdata),
    .out_rresp(out_rresp), .out_rlast(out_rlast), .out_rid(out_rid), .out_rready(out_rready),
    .out_awvalid(out_awvalid), .out_awaddr(out_awaddr), .out_awid(out_awid),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_awready(out_awready), .out_wvalid(out_wvalid), .out_wdata(out_wdata),
    .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wready(out_wready),
    .out_bvalid(out_bvalid), .out_bresp(out_bresp), .out_bid(out_bid), .out_bready(out_bready)
  );

  int tests = 0;
  int fails = 0;

  logic [43:0] exp_ar[$];      // {addr, id, len}
  logic [38:0] exp_ifu_r[$];   // {data, resp, last, id}
  logic [38:0] exp_lsu_r[$];
  logic [43:0] exp_aw[$];
  logic [36:0] exp_w[$];       // {data, strb, last}
  logic [5:0]  exp_b[$];       // {resp, id}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected beat 0x%0h, expected none", name, act);
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  // Reactive slave: data = addr + 4*beat, SLVERR for addresses 0xFxxx_xxxx, B after B_DELAY cycles
  logic rd_active = 0; logic [31:0] rd_addr = 0; logic [3:0] rd_id = 0; int rd_len = 0; int rd_beat = 0;
  logic aw_done = 0; logic w_done = 0; int b_cnt = 0; logic [3:0] b_id_s = 0;
  logic s_rst, s_ar, s_r, s_rlast, s_aw, s_w, s_b;
  logic [31:0] c_addr; logic [3:0] c_id, c_awid; logic [7:0] c_len;

  initial begin
    forever begin
      @(negedge clock);
      s_rst = reset; s_ar = out_arvalid && out_arready; s_r = out_rvalid && out_rready;
      s_rlast = out_rlast; s_aw = out_awvalid && out_awready;
      s_w = out_wvalid && out_wready && out_wlast; s_b = out_bvalid && out_bready;
      c_addr = out_araddr; c_id = out_arid; c_len = out_arlen; c_awid = out_awid;
      @(posedge clock); #1;
      if (s_rst) begin
        rd_active = 0; aw_done = 0; w_done = 0;
        out_rvalid = 0; out_rdata = 0; out_rlast = 0; out_rid = 0; out_rresp = 0;
        out_arready = 1; out_awready = 1; out_wready = 1; out_bvalid = 0; out_bid = 0;
      end else begin
        if (s_r && s_rlast) rd_active = 0;
        else if (s_r) rd_beat++;
        if (s_ar) begin
          rd_active = 1; rd_addr = c_addr; rd_id = c_id; rd_len = int'(c_len); rd_beat = 0;
        end
        out_arready = !rd_active;
        out_rvalid  = rd_active;
        out_rdata   = rd_active ? rd_addr + 32'(rd_beat * 4) : 32'h0;
        out_rlast   = rd_active && (rd_beat == rd_len);
        out_rresp   = (rd_active && rd_addr[31:28] == 4'hF) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        out_rid     = rd_active ? rd_id : 4'h0;
        if (s_b) begin aw_done = 0; w_done = 0; out_bvalid = 0; end
        if (s_aw) begin aw_done = 1; b_id_s = c_awid; b_cnt = B_DELAY; end
        if (s_w) w_done = 1;
        if (aw_done && w_done && !out_bvalid) begin
          if (b_cnt > 0) b_cnt--;
          else out_bvalid = 1;
        end
        out_bid = out_bvalid ? b_id_s : 4'h0;
        out_bresp = AXI_RESP_OKAY;
        out_awready = !aw_done;
        out_wready = !w_done;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_arvalid && out_arready) begin
          if (exp_ar.size() == 0) unexpected("ar", {out_araddr, out_arid, out_arlen});
          else check("ar", {out_araddr, out_arid, out_arlen}, exp_ar.pop_front());
        end
        if (ifu_rvalid && ifu_rready) begin
          if (exp_ifu_r.size() == 0) unexpected("ifu_r", {ifu_rdata, ifu_rresp, ifu_rlast, ifu_rid});
          else check("ifu_r", {ifu_rdata, ifu_rresp, ifu_rlast, ifu_rid}, exp_ifu_r.pop_front());
        end
        if (lsu_rvalid && lsu_rready) begin
          if (exp_lsu_r.size() == 0) unexpected("lsu_r", {lsu_rdata, lsu_rresp, lsu_rlast, lsu_rid});
          else check("lsu_r", {lsu_rdata, lsu_rresp, lsu_rlast, lsu_rid}, exp_lsu_r.pop_front());
        end
        if (out_awvalid && out_awready) begin
          if (exp_aw.size() == 0) unexpected("aw", {out_awaddr, out_awid, out_awlen});
          else check("aw", {out_awaddr, out_awid, out_awlen}, exp_aw.pop_front());
        end
        if (out_wvalid && out_wready) begin
          if (exp_w.size() == 0) unexpected("w", {out_wdata, out_wstrb, out_wlast});
          else check("w", {out_wdata, out_wstrb, out_wlast}, exp_w.pop_front());
        end
        if (lsu_bvalid && lsu_bready) begin
          if (exp_b.size() == 0) unexpected("b", {lsu_bresp, lsu_bid});
          else check("b", {lsu_bresp, lsu_bid}, exp_b.pop_front());
        end
        check("r_exclusive", ifu_rvalid & lsu_rvalid, 0);
        if (!ifu_rvalid) check("ifu_rdata_quiet", ifu_rdata, 0);
        if (!lsu_rvalid) check("lsu_rdata_quiet", lsu_rdata, 0);
        if (!out_arvalid) check("out_araddr_quiet", out_araddr, 0);
      end
    end
  end

  task automatic ifu_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    @(posedge clock); #1;
    ifu_arvalid = 1; ifu_araddr = addr; ifu_arid = id; ifu_arlen = len;
    ifu_arsize = 3'd2; ifu_arburst = AXI_BURST_INCR;
    forever begin
      @(negedge clock);
      if (ifu_arvalid && ifu_arready) break;
      if (++n > 200) begin timeout("ifu_ar"); break; end
    end
    @(posedge clock); #1;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_arburst = 0;
  endtask

  task automatic lsu_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    @(posedge clock); #1;
    lsu_arvalid = 1; lsu_araddr = addr; lsu_arid = id; lsu_arlen = len;
    lsu_arsize = 3'd2; lsu_arburst = AXI_BURST_INCR;
    forever begin
      @(negedge clock);
      if (lsu_arvalid && lsu_arready) break;
      if (++n > 200) begin timeout("lsu_ar"); break; end
    end
    @(posedge clock); #1;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0;
  endtask

  task automatic lsu_write(input logic [31:0] addr, input logic [3:0] id,
                           input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    @(posedge clock); #1;
    lsu_awvalid = 1; lsu_awaddr = addr; lsu_awid = id; lsu_awlen = 0;
    lsu_awsize = 3'd2; lsu_awburst = AXI_BURST_INCR;
    lsu_wvalid = 1; lsu_wdata = data; lsu_wstrb = strb; lsu_wlast = 1;
    while (lsu_awvalid || lsu_wvalid) begin
      logic aw_hs, w_hs;
      @(negedge clock);
      aw_hs = lsu_awvalid && lsu_awready;
      w_hs  = lsu_wvalid && lsu_wready;
      @(posedge clock); #1;
      if (aw_hs) begin lsu_awvalid = 0; lsu_awaddr = 0; lsu_awid = 0; lsu_awsize = 0; lsu_awburst = 0; end
      if (w_hs) begin lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0; end
      if (++n > 200) begin timeout("lsu_aw_w"); break; end
    end
  endtask

  // Waits for nbeats R handshakes on one side, or for its rlast when until_last is set
  task automatic wait_beats(input bit lsu_side, input int nbeats, input bit until_last);
    int n = 0;
    int beats = 0;
    logic hs, lst;
    forever begin
      @(negedge clock);
      hs  = lsu_side ? (lsu_rvalid && lsu_rready) : (ifu_rvalid && ifu_rready);
      lst = lsu_side ? lsu_rlast : ifu_rlast;
      if (hs) beats++;
      if (hs && ((until_last && lst) || (!until_last && beats == nbeats))) break;
      if (++n > 200) begin timeout(lsu_side ? "lsu_r_wait" : "ifu_r_wait"); break; end
    end
  endtask

  bit t4_done;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check("reset_handshakes_idle",
          {out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready, ifu_arready,
           ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}, 0);

    // 1: lone IFU read, one-cycle registered grant, IDLE after rlast
    exp_ar.push_back({32'h3000_0000, 4'h1, 8'd0});
    exp_ifu_r.push_back({32'h3000_0000, AXI_RESP_OKAY, 1'b1, 4'h1});
    fork
      ifu_read(32'h3000_0000, 4'h1, 8'd0);
      begin
        @(posedge clock);
        @(negedge clock);
        check("t1_no_ar_same_cycle", out_arvalid, 0);
        @(negedge clock);
        check("t1_ar_next_cycle", {out_arvalid, ifu_arready}, 2'b11);
      end
    join
    wait_beats(0, 1, 1);
    @(negedge clock);
    check("t1_idle_after_rlast", {ifu_arready, out_rready}, 0);

    // 2: ties alternate, LSU first after reset, then IFU, then LSU
    exp_ar.push_back({32'h1000_0000, 4'h2, 8'd0});
    exp_ar.push_back({32'h3000_0010, 4'h3, 8'd0});
    exp_ar.push_back({32'h1000_0020, 4'h4, 8'd0});
    exp_lsu_r.push_back({32'h1000_0000, AXI_RESP_OKAY, 1'b1, 4'h2});
    exp_ifu_r.push_back({32'h3000_0010, AXI_RESP_OKAY, 1'b1, 4'h3});
    exp_lsu_r.push_back({32'h1000_0020, AXI_RESP_OKAY, 1'b1, 4'h4});
    fork
      ifu_read(32'h3000_0010, 4'h3, 8'd0);
      begin
        lsu_read(32'h1000_0000, 4'h2, 8'd0);
        wait_beats(1, 1, 1);
        lsu_read(32'h1000_0020, 4'h4, 8'd0);
      end
    join
    wait_beats(1, 1, 1);
    repeat (2) @(posedge clock);

    // 3: LSU write with slow B holds the IFU off until one cycle after the B handshake
    exp_aw.push_back({32'h0200_4000, 4'h5, 8'd0});
    exp_w.push_back({32'hDEAD_BEEF, 4'hF, 1'b1});
    exp_b.push_back({AXI_RESP_OKAY, 4'h5});
    exp_ar.push_back({32'h3000_0020, 4'h6, 8'd0});
    exp_ifu_r.push_back({32'h3000_0020, AXI_RESP_OKAY, 1'b1, 4'h6});
    fork
      lsu_write(32'h0200_4000, 4'h5, 32'hDEAD_BEEF, 4'hF);
      begin
        repeat (2) @(posedge clock);
        ifu_read(32'h3000_0020, 4'h6, 8'd0);
      end
      begin
        int n = 0;
        forever begin
          @(negedge clock);
          if (lsu_bvalid && lsu_bready) break;
          check("t3_ifu_held_off", ifu_arready, 0);
          if (++n > 200) begin timeout("t3_b"); break; end
        end
        @(negedge clock);
        check("t3_idle_bubble", ifu_arready, 0);
        @(negedge clock);
        check("t3_ifu_granted", ifu_arready, 1);
      end
    join
    wait_beats(0, 1, 1);
    repeat (2) @(posedge clock);

    // 4: IFU burst of 4 with rready toggling
    for (int i = 0; i < 4; i++)
      exp_ifu_r.push_back({32'h3000_0100 + 32'(i * 4), AXI_RESP_OKAY, (i == 3), 4'h7});
    exp_ar.push_back({32'h3000_0100, 4'h7, 8'd3});
    t4_done = 0;
    fork
      begin
        int n = 0;
        int beats = 0;
        ifu_read(32'h3000_0100, 4'h7, 8'd3);
        forever begin
          @(negedge clock);
          check("t4_rready_follow", out_rready, ifu_rready);
          if (ifu_rvalid && ifu_rready) beats++;
          if (ifu_rvalid && ifu_rready && ifu_rlast) break;
          if (++n > 200) begin timeout("t4_burst"); break; end
        end
        check("t4_beat_count", beats, 4);
        t4_done = 1;
        @(negedge clock);
        check("t4_idle_after_rlast", ifu_arready, 0);
      end
      begin
        while (!t4_done) begin
          @(posedge clock); #1;
          ifu_rready = !ifu_rready;
        end
      end
    join
    ifu_rready = 1;
    repeat (2) @(posedge clock);

    // 5: SLVERR read ends normally and the next grant proceeds
    exp_ar.push_back({32'hF000_0010, 4'h8, 8'd0});
    exp_lsu_r.push_back({32'hF000_0010, 2'b10, 1'b1, 4'h8});
    exp_ar.push_back({32'h3000_0030, 4'h9, 8'd0});
    exp_ifu_r.push_back({32'h3000_0030, AXI_RESP_OKAY, 1'b1, 4'h9});
    lsu_read(32'hF000_0010, 4'h8, 8'd0);
    wait_beats(1, 1, 1);
    ifu_read(32'h3000_0030, 4'h9, 8'd0);
    wait_beats(0, 1, 1);
    repeat (2) @(posedge clock);

    // 6: reset in the middle of an LSU burst
    exp_ar.push_back({32'h1000_0100, 4'hA, 8'd7});
    exp_lsu_r.push_back({32'h1000_0100, AXI_RESP_OKAY, 1'b0, 4'hA});
    exp_lsu_r.push_back({32'h1000_0104, AXI_RESP_OKAY, 1'b0, 4'hA});
    lsu_read(32'h1000_0100, 4'hA, 8'd7);
    wait_beats(1, 2, 0);
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    check("t6_valids_after_reset",
          {out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready,
           ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_bvalid}, 0);
    exp_ar.push_back({32'h3000_0200, 4'hB, 8'd0});
    exp_ifu_r.push_back({32'h3000_0200, AXI_RESP_OKAY, 1'b1, 4'hB});
    fork
      ifu_read(32'h3000_0200, 4'hB, 8'd0);
      begin
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        check("t6_ifu_granted", {out_arvalid, ifu_arready, out_araddr}, {2'b11, 32'h3000_0200});
      end
    join
    wait_beats(0, 1, 1);
    repeat (3) @(posedge clock);

    @(negedge clock);
    check("sb_ar_drained", exp_ar.size(), 0);
    check("sb_ifu_r_drained", exp_ifu_r.size(), 0);
    check("sb_lsu_r_drained", exp_lsu_r.size(), 0);
    check("sb_aw_w_b_drained", exp_aw.size() + exp_w.size() + exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
